// File: rtl/chicken_pkg.sv
// Shared encodings for the chicken-race phase controller: state codes, player-count
// encodings and the player-count decode helper.
package chicken_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_WAIT_FLIP = 3'b001,
    ST_REVEAL    = 3'b010,
    ST_JUDGE     = 3'b011,
    ST_MOVE      = 3'b100,
    ST_NEXT_TURN = 3'b101,
    ST_WIN       = 3'b110
  } state_t;

  localparam logic [1:0] NP_2 = 2'b00;
  localparam logic [1:0] NP_3 = 2'b01;
  localparam logic [1:0] NP_4 = 2'b10;

  localparam int MAX_PLAYERS = 4;

  function automatic logic [2:0] player_count(input logic [1:0] np);
    case (np)
      NP_2:    return 3'd2;
      NP_3:    return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/turn_phase_ctrl_if.sv
// Control/status bundle between the tile-flip logic, the turn tracker and the phase FSM.
// PW is the per-player position width, $clog2(TRACK_LEN).
interface turn_phase_ctrl_if #(parameter int PW = 5);
  logic            start;
  logic [1:0]      n_players;
  logic [1:0]      cur_turn;
  logic            flip_valid;
  logic            flip_match;
  logic [2:0]      q;
  logic            next_turn;
  logic            reveal_on;
  logic [4*PW-1:0] pos_flat;
  logic            win_valid;
  logic [1:0]      winner;

  modport slave (
    input  start, n_players, cur_turn, flip_valid, flip_match,
    output q, next_turn, reveal_on, pos_flat, win_valid, winner
  );

  modport master (
    output start, n_players, cur_turn, flip_valid, flip_match,
    input  q, next_turn, reveal_on, pos_flat, win_valid, winner
  );
endinterface

// File: rtl/phase_timer.sv
// Load/count-down timer: load_i presets the count, en_i decrements it, and done_o is
// high on the last enabled cycle of the interval (count == 1), giving exactly load_val cycles.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/turn_phase_ctrl.sv
// Turn phase FSM (flip -> reveal -> judge -> move -> next_turn) with per-player track state.
// Optional flip timeout in WAIT_FLIP when TURN_TIMEOUT_EN is defined.
module turn_phase_ctrl
  import chicken_pkg::*;
#(
  parameter int TRACK_LEN      = 24,
  parameter int WIN_LAPS       = 1,
  parameter int REVEAL_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  turn_phase_ctrl_if.slave  bus
);

  localparam int            PW       = $clog2(TRACK_LEN);
  localparam int            RW       = $clog2(REVEAL_CYCLES + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(TRACK_LEN - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q  [MAX_PLAYERS];
  logic [PW-1:0] pos_d  [MAX_PLAYERS];
  logic [1:0]    laps_q [MAX_PLAYERS];
  logic [1:0]    laps_d [MAX_PLAYERS];
  logic [2:0]    nplay_q, nplay_d;
  logic          match_q, match_d;
  logic [1:0]    winner_q, winner_d;
  logic          next_turn_q;
  logic          enter_reveal;
  logic          reveal_done;
  logic          timeout;
  logic [PW-1:0] cur_pos;
  logic [1:0]    cur_laps;
  logic [1:0]    lap_nxt;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    laps_d       = laps_q;
    nplay_d      = nplay_q;
    match_d      = match_q;
    winner_d     = winner_q;
    enter_reveal = 1'b0;
    cur_pos      = pos_q[bus.cur_turn];
    cur_laps     = laps_q[bus.cur_turn];
    lap_nxt      = (cur_laps == 2'd3) ? 2'd3 : cur_laps + 2'd1;

    case (state_q)
      ST_IDLE, ST_WIN: begin
        if (bus.start) begin
          state_d  = ST_WAIT_FLIP;
          nplay_d  = player_count(bus.n_players);
          winner_d = '0;
          for (int i = 0; i < MAX_PLAYERS; i++) begin
            pos_d[i]  = '0;
            laps_d[i] = '0;
          end
        end
      end
      // A flip on the same cycle the timeout expires still counts as a flip.
      ST_WAIT_FLIP: begin
        if (bus.flip_valid) begin
          state_d      = ST_REVEAL;
          match_d      = bus.flip_match;
          enter_reveal = 1'b1;
        end else if (timeout) begin
          state_d = ST_NEXT_TURN;
        end
      end
      ST_REVEAL: begin
        if (reveal_done) state_d = ST_JUDGE;
      end
      ST_JUDGE: begin
        state_d = (match_q && ({1'b0, bus.cur_turn} < nplay_q)) ? ST_MOVE : ST_NEXT_TURN;
      end
      ST_MOVE: begin
        state_d = ST_NEXT_TURN;
        if (cur_pos == POS_LAST) begin
          pos_d[bus.cur_turn]  = '0;
          laps_d[bus.cur_turn] = lap_nxt;
          if (lap_nxt == 2'(WIN_LAPS)) begin
            state_d  = ST_WIN;
            winner_d = bus.cur_turn;
          end
        end else begin
          pos_d[bus.cur_turn] = cur_pos + 1'b1;
        end
      end
      ST_NEXT_TURN: state_d = ST_WAIT_FLIP;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nplay_q     <= 3'd2;
      match_q     <= 1'b0;
      winner_q    <= '0;
      next_turn_q <= 1'b0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        pos_q[i]  <= '0;
        laps_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      nplay_q     <= nplay_d;
      match_q     <= match_d;
      winner_q    <= winner_d;
      next_turn_q <= (state_d == ST_NEXT_TURN);
      pos_q       <= pos_d;
      laps_q      <= laps_d;
    end
  end

  phase_timer #(.W(RW)) u_reveal_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (enter_reveal),
    .en_i       (state_q == ST_REVEAL),
    .load_val_i (RW'(REVEAL_CYCLES)),
    .done_o     (reveal_done)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic enter_wait;

  // Reloading on every entry means the count never carries over between turns.
  assign enter_wait = (state_d == ST_WAIT_FLIP) && (state_q != ST_WAIT_FLIP);

  phase_timer #(.W(TW)) u_timeout_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (enter_wait),
    .en_i       (state_q == ST_WAIT_FLIP),
    .load_val_i (TW'(TIMEOUT_CYCLES)),
    .done_o     (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign bus.q         = state_q;
  assign bus.next_turn = next_turn_q;
  assign bus.reveal_on = (state_q == ST_REVEAL);
  assign bus.win_valid = (state_q == ST_WIN);
  assign bus.winner    = winner_q;
  assign bus.pos_flat  = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};

endmodule

// File: tb/tb_turn_phase_ctrl.sv
// Directed bench for turn_phase_ctrl; the bench plays the turn tracker by driving cur_turn.
// The timeout scenario is compiled in only with TURN_TIMEOUT_EN.
module tb_turn_phase_ctrl;
  import chicken_pkg::*;

  localparam int TRACK_LEN      = 24;
  localparam int WIN_LAPS       = 1;
  localparam int REVEAL_CYCLES  = 50;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int PW             = $clog2(TRACK_LEN);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  turn_phase_ctrl_if #(.PW(PW)) bus ();

  turn_phase_ctrl #(
    .TRACK_LEN      (TRACK_LEN),
    .WIN_LAPS       (WIN_LAPS),
    .REVEAL_CYCLES  (REVEAL_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pos_of(input int k);
    return bus.pos_flat[k*PW +: PW];
  endfunction

  task automatic wait_q(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.q === s) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = (bus.q === s);
  endtask

  // One full turn from WAIT_FLIP; leaves the DUT back in WAIT_FLIP unless it won.
  task automatic do_turn(input logic [1:0] pl, input logic m,
                         output logic [2:0] after_judge, output logic [2:0] after_move);
    bit ok;
    bus.cur_turn   = pl;
    bus.flip_valid = 1'b1;
    bus.flip_match = m;
    step();
    bus.flip_valid = 1'b0;
    bus.flip_match = 1'b0;
    wait_q(ST_JUDGE, 2 * REVEAL_CYCLES, ok);
    step();
    after_judge = bus.q;
    after_move  = after_judge;
    if (after_judge == ST_MOVE) begin
      step();
      after_move = bus.q;
    end
    if (after_move == ST_NEXT_TURN) step();
  endtask

  task automatic test_reset();
    bus.start = 0; bus.n_players = 0; bus.cur_turn = 0; bus.flip_valid = 0; bus.flip_match = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.q !== 3'b000) begin bad++; $display("FAIL rst_q: got %b want 000", bus.q); end
    total++; if (bus.next_turn !== 1'b0) begin bad++; $display("FAIL rst_next_turn: got %b want 0", bus.next_turn); end
    total++; if (bus.reveal_on !== 1'b0) begin bad++; $display("FAIL rst_reveal_on: got %b want 0", bus.reveal_on); end
    total++; if (bus.pos_flat !== '0) begin bad++; $display("FAIL rst_pos: got %h want 0", bus.pos_flat); end
    total++; if (bus.win_valid !== 1'b0) begin bad++; $display("FAIL rst_win_valid: got %b want 0", bus.win_valid); end
    total++; if (bus.winner !== 2'd0) begin bad++; $display("FAIL rst_winner: got %0d want 0", bus.winner); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_miss();
    int n;
    bus.n_players = 2'b00; bus.cur_turn = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++; if (bus.q !== 3'b001) begin bad++; $display("FAIL miss_start: q=%b want 001", bus.q); end
    bus.flip_valid = 1'b1; bus.flip_match = 1'b0;
    step();
    bus.flip_valid = 1'b0;
    total++; if (bus.reveal_on !== 1'b1 || bus.q !== 3'b010) begin bad++; $display("FAIL miss_reveal: q=%b reveal_on=%b want 010/1", bus.q, bus.reveal_on); end
    n = 0;
    while (bus.q === 3'b010 && n < 200) begin n++; step(); end
    total++; if (n != 50) begin bad++; $display("FAIL miss_reveal_len: got %0d cycles want 50", n); end
    total++; if (bus.q !== 3'b011 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL miss_judge: q=%b next_turn=%b want 011/0", bus.q, bus.next_turn); end
    step();
    total++; if (bus.q !== 3'b101 || bus.next_turn !== 1'b1) begin bad++; $display("FAIL miss_strobe: q=%b next_turn=%b want 101/1", bus.q, bus.next_turn); end
    step();
    total++; if (bus.q !== 3'b001 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL miss_strobe_end: q=%b next_turn=%b want 001/0", bus.q, bus.next_turn); end
    total++; if (bus.pos_flat !== '0) begin bad++; $display("FAIL miss_pos: got %h want 0", bus.pos_flat); end
  endtask

  task automatic test_move();
    logic [2:0] aj, am;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_turn(2'd1, 1'b1, aj, am);
      total++; if (am !== 3'b101) begin bad++; $display("FAIL move_setup%0d: q=%b want 101", i, am); end
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++; if (bus.q !== 3'b001 || pos_of(1) !== 5'd5) begin bad++; $display("FAIL move_start_ignored: q=%b pos1=%0d want 001/5", bus.q, pos_of(1)); end
    bus.cur_turn = 2'd1; bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
    step();
    bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
    wait_q(ST_JUDGE, 2 * REVEAL_CYCLES, ok);
    total++; if (!ok || bus.next_turn !== 1'b0) begin bad++; $display("FAIL move_judge: q=%b next_turn=%b want 011/0", bus.q, bus.next_turn); end
    step();
    total++; if (bus.q !== 3'b100 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL move_move: q=%b next_turn=%b want 100/0", bus.q, bus.next_turn); end
    step();
    total++; if (bus.q !== 3'b101 || bus.next_turn !== 1'b1) begin bad++; $display("FAIL move_strobe: q=%b next_turn=%b want 101/1", bus.q, bus.next_turn); end
    total++; if (pos_of(1) !== 5'd6 || pos_of(0) !== 5'd0) begin bad++; $display("FAIL move_pos: pos1=%0d pos0=%0d want 6/0", pos_of(1), pos_of(0)); end
    step();
    total++; if (bus.q !== 3'b001 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL move_back: q=%b next_turn=%b want 001/0", bus.q, bus.next_turn); end
  endtask

  task automatic test_ignored();
    logic [2:0] aj, am;
    int n;
    bus.cur_turn = 2'd0; bus.flip_valid = 1'b1; bus.flip_match = 1'b0;
    step();
    n = 0;
    while (bus.q === 3'b010 && n < 200) begin
      n++;
      bus.flip_valid = (n == 3 || n == 40);
      bus.flip_match = bus.flip_valid;
      step();
    end
    bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
    total++; if (n != 50) begin bad++; $display("FAIL ign_reveal_len: got %0d cycles want 50", n); end
    step();
    total++; if (bus.q !== 3'b101) begin bad++; $display("FAIL ign_match_latch: q=%b want 101", bus.q); end
    bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
    step();
    bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
    step();
    total++; if (bus.q !== 3'b001 || pos_of(0) !== 5'd0) begin bad++; $display("FAIL ign_next_turn_flip: q=%b pos0=%0d want 001/0", bus.q, pos_of(0)); end
    do_turn(2'd3, 1'b1, aj, am);
    total++; if (aj !== 3'b101 || pos_of(3) !== 5'd0) begin bad++; $display("FAIL ign_player3: q=%b pos3=%0d want 101/0", aj, pos_of(3)); end
  endtask

  task automatic test_win();
    logic [2:0] aj, am;
    bit ok;
    for (int i = 0; i < 23; i++) begin
      do_turn(2'd0, 1'b1, aj, am);
      total++; if (am !== 3'b101) begin bad++; $display("FAIL win_setup%0d: q=%b want 101", i, am); end
    end
    total++; if (pos_of(0) !== 5'd23) begin bad++; $display("FAIL win_pos23: got %0d want 23", pos_of(0)); end
    bus.cur_turn = 2'd0; bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
    step();
    bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
    wait_q(ST_JUDGE, 2 * REVEAL_CYCLES, ok);
    step();
    total++; if (!ok || bus.q !== 3'b100) begin bad++; $display("FAIL win_move: q=%b want 100", bus.q); end
    step();
    total++; if (bus.q !== 3'b110 || bus.win_valid !== 1'b1 || bus.winner !== 2'd0) begin bad++; $display("FAIL win_state: q=%b win_valid=%b winner=%0d want 110/1/0", bus.q, bus.win_valid, bus.winner); end
    total++; if (bus.next_turn !== 1'b0 || pos_of(0) !== 5'd0) begin bad++; $display("FAIL win_wrap: next_turn=%b pos0=%0d want 0/0", bus.next_turn, pos_of(0)); end
    bus.flip_valid = 1'b1;
    repeat (3) step();
    bus.flip_valid = 1'b0;
    total++; if (bus.q !== 3'b110 || bus.win_valid !== 1'b1 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL win_hold: q=%b win_valid=%b next_turn=%b want 110/1/0", bus.q, bus.win_valid, bus.next_turn); end
    bus.n_players = 2'b10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++; if (bus.q !== 3'b001 || bus.pos_flat !== '0 || bus.win_valid !== 1'b0) begin bad++; $display("FAIL win_restart: q=%b pos=%h win_valid=%b want 001/0/0", bus.q, bus.pos_flat, bus.win_valid); end
    do_turn(2'd3, 1'b1, aj, am);
    total++; if (aj !== 3'b100 || pos_of(3) !== 5'd1) begin bad++; $display("FAIL win_four_players: q=%b pos3=%0d want 100/1", aj, pos_of(3)); end
  endtask

  task automatic test_reset_mid();
    bus.cur_turn = 2'd3; bus.flip_valid = 1'b1; bus.flip_match = 1'b1;
    step();
    bus.flip_valid = 1'b0; bus.flip_match = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.q !== 3'b000 || bus.reveal_on !== 1'b0) begin bad++; $display("FAIL mid_rst_q: q=%b reveal_on=%b want 000/0", bus.q, bus.reveal_on); end
    total++; if (bus.pos_flat !== '0 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL mid_rst_pos: pos=%h next_turn=%b want 0/0", bus.pos_flat, bus.next_turn); end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    total++; if (bus.q !== 3'b000 || bus.next_turn !== 1'b0) begin bad++; $display("FAIL mid_rst_after: q=%b next_turn=%b want 000/0", bus.q, bus.next_turn); end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.n_players = 2'b00; bus.cur_turn = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.q === 3'b001 && n < 100) begin n++; step(); end
    total++; if (n != 10 || bus.q !== 3'b101) begin bad++; $display("FAIL to_expire: waited %0d q=%b want 10/101", n, bus.q); end
    step();
    repeat (9) step();
    total++; if (bus.q !== 3'b001) begin bad++; $display("FAIL to_cycle10: q=%b want 001", bus.q); end
    bus.flip_valid = 1'b1;
    step();
    bus.flip_valid = 1'b0;
    total++; if (bus.q !== 3'b010) begin bad++; $display("FAIL to_flip_wins: q=%b want 010", bus.q); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_miss();
    test_move();
    test_ignored();
    test_win();
    test_reset_mid();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
